// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: in-order instruction prefetcher with a DEPTH-entry FIFO and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN turns a misaligned redirect target into a single fault entry.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        instr_fault
`endif
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic          w_pop;
    logic          w_grant;
    logic          w_mem_push;
    logic          w_drop;
    logic          w_push;
    logic          w_req_ok;
    logic [CW:0]   w_inflight;
    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_push_data;
    logic [31:0]   w_push_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {FS_RUN, FS_WAIT, FS_IDLE} fault_state_t;

    fault_state_t  r_fstate;
    logic          r_fifo_fault [DEPTH];
    logic [31:0]   r_fault_pc;
    logic          w_fault_push;
    logic          w_misaligned;

    // The fault entry is injected only once every stale response has drained.
    assign w_misaligned = redirect_pc[1:0] != 2'b00;
    assign w_fault_push = (r_fstate == FS_WAIT) && (r_outstanding == '0);
    assign w_req_ok     = r_fstate == FS_RUN;
    assign w_push       = w_mem_push || w_fault_push;
    assign w_push_data  = w_fault_push ? 32'h0000_0013 : mem_rdata;
    assign w_push_pc    = w_fault_push ? r_fault_pc : r_resp_pc;
    assign instr_fault  = instr_valid && r_fifo_fault[r_rd_ptr];
`else
    logic          w_unused;

    assign w_unused     = ^redirect_pc[1:0];
    assign w_req_ok     = 1'b1;
    assign w_push       = w_mem_push;
    assign w_push_data  = mem_rdata;
    assign w_push_pc    = r_resp_pc;
`endif

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign instr_valid   = r_count != '0;
    assign instr         = r_fifo_data[r_rd_ptr];
    assign instr_pc      = r_fifo_pc[r_rd_ptr];
    assign w_pop         = instr_valid && instr_ready;

    // Credit check counts a same-cycle pop so back-to-back fetch sustains with DEPTH=2.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding} - (CW + 1)'(w_pop);
    assign mem_req    = !reset && !redirect && w_req_ok && (w_inflight < DEPTH_W);
    assign mem_addr   = r_fetch_pc;
    assign w_grant    = mem_req && mem_gnt;
    assign w_drop     = mem_rvalid && (r_discard != '0);
    assign w_mem_push = mem_rvalid && (r_discard == '0);

    always_ff @(posedge clk) begin
        if (!reset && !redirect && w_push) begin
            r_fifo_data[r_wr_ptr]  <= w_push_data;
            r_fifo_pc[r_wr_ptr]    <= w_push_pc;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fifo_fault[r_wr_ptr] <= w_fault_push;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fstate      <= FS_RUN;
            r_fault_pc    <= '0;
`endif
        end else if (redirect) begin
            // Every request still in flight, minus one returning now, belongs to the old stream.
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= r_outstanding - CW'(mem_rvalid);
            r_discard     <= r_outstanding - CW'(mem_rvalid);
`ifdef FETCH_ALIGN_CHECK_EN
            r_fstate      <= w_misaligned ? FS_WAIT : FS_RUN;
            r_fault_pc    <= redirect_pc;
`endif
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_mem_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(mem_rvalid);
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_fault_push) begin
                r_fstate <= FS_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: directed and randomized checks of fetch_unit against a transaction-level model
// (queue of in-flight requests tagged with a flush epoch, queue of deliverable instructions).

module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        instr_fault;
`endif

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .instr_fault (instr_fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] epoch;
        logic [31:0] cyc;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } ent_t;

    req_t        q_pend[$];
    ent_t        q_fifo[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          started = 0;
    logic [31:0] epoch = '0;
    logic [31:0] exp_fetch = RESET_PC;
    bit          m_fault_wait = 0;
    bit          m_fault_block = 0;
    logic [31:0] m_fault_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: advanced once per cycle, mid-cycle, once all inputs are settled.
    always @(negedge clk) begin
        req_t r;
        bit   exp_valid;
        bit   pop;
        bit   exp_req;
        int   inflight;
        if (reset) begin
            started = 1;
            check("mem_req_in_reset", {31'd0, mem_req}, 32'd0);
            q_pend.delete();
            q_fifo.delete();
            exp_fetch     = RESET_PC;
            epoch         = epoch + 1;
            m_fault_wait  = 0;
            m_fault_block = 0;
        end else if (started) begin
            exp_valid = q_fifo.size() != 0;
            check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("instr_pc", instr_pc, q_fifo[0].pc);
                check("instr", instr, q_fifo[0].data);
`ifdef FETCH_ALIGN_CHECK_EN
                check("instr_fault", {31'd0, instr_fault}, {31'd0, q_fifo[0].fault});
`endif
            end
            pop      = exp_valid && instr_ready;
            inflight = int'(q_fifo.size()) + int'(q_pend.size()) - int'(pop);
            exp_req  = !redirect && !m_fault_block && (inflight < int'(DEPTH));
            check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            if (exp_req) check("mem_addr", mem_addr, exp_fetch);

            if (redirect) begin
                q_fifo.delete();
                epoch = epoch + 1;
                if (mem_rvalid && q_pend.size() != 0) r = q_pend.pop_front();
                exp_fetch = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
                m_fault_wait  = redirect_pc[1:0] != 2'b00;
                m_fault_block = redirect_pc[1:0] != 2'b00;
                m_fault_pc    = redirect_pc;
`endif
            end else begin
                if (pop) void'(q_fifo.pop_front());
                if (mem_rvalid && q_pend.size() != 0) begin
                    r = q_pend.pop_front();
                    if (r.epoch == epoch) q_fifo.push_back('{r.addr, mem_word(r.addr), 1'b0});
                end else if (m_fault_wait && q_pend.size() == 0) begin
                    q_fifo.push_back('{m_fault_pc, 32'h0000_0013, 1'b1});
                    m_fault_wait = 0;
                end
                if (exp_req && mem_gnt) begin
                    q_pend.push_back('{exp_fetch, epoch, cyc});
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
    end

    // Drive one cycle of inputs; memory answers the oldest request with probability pct.
    task automatic tick(input bit gnt, input bit rdy, input bit rdr, input logic [31:0] rpc,
                        input int pct, input bit rst);
        @(posedge clk);
        #1;
        reset       = rst;
        mem_gnt     = gnt;
        instr_ready = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        if (!rst && q_pend.size() != 0 && int'(q_pend[0].cyc) < cyc &&
            int'($urandom_range(99)) < pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(q_pend[0].addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom();
        end
    endtask

    task automatic do_reset();
        tick(0, 0, 0, '0, 0, 1);
        tick(0, 0, 0, '0, 0, 1);
    endtask

    // Run with full-speed memory and consumer; check the first n popped pcs against a ramp.
    task automatic expect_pops(input string name, input logic [31:0] first, input int n);
        int got = 0;
        for (int k = 0; k < 20 && got < n; k++) begin
            tick(1, 1, 0, '0, 100, 0);
            @(negedge clk);
            if (instr_valid) begin
                check(name, instr_pc, first + 32'(4 * got));
                check({name, "_data"}, instr, mem_word(first + 32'(4 * got)));
                got++;
            end
        end
        check({name, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        logic [31:0] rpc;

        // Streaming from reset with a 1-cycle memory.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick(1, 1, 0, '0, 100, 0);
            @(negedge clk);
            check("t1_mem_req", {31'd0, mem_req}, 32'd1);
            check("t1_mem_addr", mem_addr, 32'(4 * k));
            check("t1_valid", {31'd0, instr_valid}, (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) check("t1_pc", instr_pc, 32'(4 * (k - 2)));
        end

        // Consumer stall: fetch stops after filling the FIFO, head held.
        do_reset();
        grants = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1, 0, 0, '0, 100, 0);
            @(negedge clk);
            if (mem_req && mem_gnt) grants++;
            if (k >= 2) check("t2_hold_pc", instr_pc, 32'h0);
        end
        check("t2_grants", 32'(grants), 32'd2);
        expect_pops("t2_order", 32'h0, 3);

        // Redirect with two requests in flight.
        do_reset();
        tick(1, 1, 0, '0, 0, 0);
        tick(1, 1, 0, '0, 0, 0);
        tick(1, 1, 0, '0, 0, 0);
        @(negedge clk);
        check("t3_full_no_req", {31'd0, mem_req}, 32'd0);
        tick(1, 1, 1, 32'h100, 0, 0);
        expect_pops("t3_after_redirect", 32'h100, 2);

        // Redirect in the same cycle as a returning response.
        do_reset();
        tick(1, 1, 0, '0, 0, 0);
        tick(1, 1, 0, '0, 0, 0);
        tick(1, 1, 1, 32'h200, 100, 0);
        @(negedge clk);
        check("t4_rvalid_with_redirect", {31'd0, mem_rvalid}, 32'd1);
        expect_pops("t4_after_redirect", 32'h200, 2);

        // Address wrap at the top of the space.
        do_reset();
        tick(1, 1, 1, 32'hFFFF_FFFC, 100, 0);
        tick(1, 1, 0, '0, 100, 0);
        @(negedge clk);
        check("t5_top_addr", mem_addr, 32'hFFFF_FFFC);
        check("t5_top_req", {31'd0, mem_req}, 32'd1);
        tick(1, 1, 0, '0, 100, 0);
        @(negedge clk);
        check("t5_wrap_addr", mem_addr, 32'h0000_0000);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned target: stale responses drain, then one fault entry, then idle.
        do_reset();
        tick(1, 1, 0, '0, 0, 0);
        tick(1, 1, 0, '0, 0, 0);
        tick(1, 1, 1, 32'h102, 0, 0);
        grants = 0;
        for (int k = 0; k < 8 && grants == 0; k++) begin
            tick(1, 0, 0, '0, 100, 0);
            @(negedge clk);
            check("t6_no_req", {31'd0, mem_req}, 32'd0);
            if (instr_valid) grants = 1;
        end
        check("t6_fault_seen", 32'(grants), 32'd1);
        check("t6_fault_bit", {31'd0, instr_fault}, 32'd1);
        check("t6_fault_pc", instr_pc, 32'h102);
        check("t6_fault_instr", instr, 32'h0000_0013);
        tick(1, 1, 0, '0, 100, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1, 1, 0, '0, 100, 0);
            @(negedge clk);
            check("t6_idle_valid", {31'd0, instr_valid}, 32'd0);
            check("t6_idle_req", {31'd0, mem_req}, 32'd0);
        end
        tick(1, 1, 1, 32'h40, 100, 0);
        expect_pops("t6_recover", 32'h40, 2);
`else
        // Low address bits of the target are ignored.
        do_reset();
        tick(1, 1, 1, 32'h102, 100, 0);
        tick(1, 1, 0, '0, 100, 0);
        @(negedge clk);
        check("t6_aligned_addr", mem_addr, 32'h100);
        expect_pops("t6_aligned_pops", 32'h100, 2);
`endif

        // Randomized traffic, redirects and occasional resets against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4 : $urandom();
`ifdef FETCH_ALIGN_CHECK_EN
            rpc[1:0] = 2'b00;
`endif
            tick($urandom_range(9) < 7, $urandom_range(9) < 6, $urandom_range(39) == 0,
                 rpc, 60, $urandom_range(499) == 0);
        end
        tick(0, 0, 0, '0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
